wshb_arbiter_2: RTL and testbench

WSHB_ARBITER_2 -- requirements
Module: wshb_arbiter_2

---
 rtl/wshb_if.sv | 29 ++
 rtl/wshb_arbiter_2.sv | 78 +++++++
 tb/tb_wshb_arbiter_2.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle (32-bit data, 32-bit byte address) shared by the
// arbiter's requester ports and its target port.
interface wshb_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_ms;
  logic [DW-1:0]   dat_sm;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output cyc, stb, we, adr, sel, cti, bte, dat_ms,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_arbiter_2.sv
// Two-requester Wishbone arbiter: round-robin on ties, grant held while the
// owner keeps cyc high, watchdog that errors out a stalled slave access.
module wshb_arbiter_2 #(
  parameter int TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   rst,
  wshb_if.slave  wb_m0,
  wshb_if.slave  wb_m1,
  wshb_if.master wb_s
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t         state;
  logic           last;
  logic [WDW-1:0] wdt;

  logic g0, g1, tmo, own_cyc, s_resp;

  assign g0      = (state == GNT0);
  assign g1      = (state == GNT1);
  assign own_cyc = g1 ? wb_m1.cyc : wb_m0.cyc;
  assign s_resp  = wb_s.ack | wb_s.err | wb_s.rty;
  assign tmo     = (TIMEOUT > 0) && (state != IDLE) && (wdt == WDW'(TIMEOUT));

  // Request side: mux from the owner; cyc/stb/we gated off in IDLE and on timeout.
  assign wb_s.cyc    = ~tmo & ((g0 & wb_m0.cyc) | (g1 & wb_m1.cyc));
  assign wb_s.stb    = ~tmo & ((g0 & wb_m0.stb) | (g1 & wb_m1.stb));
  assign wb_s.we     = ~tmo & ((g0 & wb_m0.we)  | (g1 & wb_m1.we));
  assign wb_s.adr    = g1 ? wb_m1.adr    : wb_m0.adr;
  assign wb_s.sel    = g1 ? wb_m1.sel    : wb_m0.sel;
  assign wb_s.cti    = g1 ? wb_m1.cti    : wb_m0.cti;
  assign wb_s.bte    = g1 ? wb_m1.bte    : wb_m0.bte;
  assign wb_s.dat_ms = g1 ? wb_m1.dat_ms : wb_m0.dat_ms;

  // Response side: only the owner ever sees a termination.
  assign wb_m0.ack    = g0 & ~tmo & wb_s.ack;
  assign wb_m0.err    = g0 & (tmo | wb_s.err);
  assign wb_m0.rty    = g0 & ~tmo & wb_s.rty;
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.ack    = g1 & ~tmo & wb_s.ack;
  assign wb_m1.err    = g1 & (tmo | wb_s.err);
  assign wb_m1.rty    = g1 & ~tmo & wb_s.rty;
  assign wb_m1.dat_sm = wb_s.dat_sm;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      wdt   <= '0;
    end else begin
      wdt <= '0;
      unique case (state)
        IDLE: begin
          // last names the previous owner, so a tie goes to the other one
          if (wb_m0.cyc && (!wb_m1.cyc || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (wb_m1.cyc) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (tmo || !own_cyc) begin
            state <= IDLE;
            if (tmo) last <= g1;
          end else if (TIMEOUT > 0 && wb_s.stb && !s_resp) begin
            wdt <= wdt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wshb_arbiter_2.sv
// Directed + random bench for wshb_arbiter_2 against a small BlockRAM slave.
module tb_wshb_arbiter_2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  wshb_arbiter_2 #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_m0 (m0_if),
    .wb_m1 (m1_if),
    .wb_s  (s_if)
  );

  // requester drive / observe arrays
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [2:0]  m_cti [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic        m_rty [2];
  logic [31:0] m_dsm [2];

  assign m0_if.cyc = m_cyc[0];  assign m1_if.cyc = m_cyc[1];
  assign m0_if.stb = m_stb[0];  assign m1_if.stb = m_stb[1];
  assign m0_if.we  = m_we[0];   assign m1_if.we  = m_we[1];
  assign m0_if.adr = m_adr[0];  assign m1_if.adr = m_adr[1];
  assign m0_if.dat_ms = m_dat[0]; assign m1_if.dat_ms = m_dat[1];
  assign m0_if.cti = m_cti[0];  assign m1_if.cti = m_cti[1];
  assign m0_if.sel = 4'hF;      assign m1_if.sel = 4'hF;
  assign m0_if.bte = 2'b00;     assign m1_if.bte = 2'b00;
  assign m_ack[0] = m0_if.ack;  assign m_ack[1] = m1_if.ack;
  assign m_err[0] = m0_if.err;  assign m_err[1] = m1_if.err;
  assign m_rty[0] = m0_if.rty;  assign m_rty[1] = m1_if.rty;
  assign m_dsm[0] = m0_if.dat_sm; assign m_dsm[1] = m1_if.dat_sm;

  // BlockRAM slave: combinational write ack, registered read ack; mute ties ack low
  logic        mute = 1'b0;
  logic [31:0] mem [0:63];
  logic        rd_ack;
  logic [31:0] rdat;
  logic [5:0]  ridx;
  assign ridx = s_if.adr[7:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack <= 1'b0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      rd_ack <= s_if.cyc & s_if.stb & ~s_if.we & ~rd_ack & ~mute;
      rdat   <= mem[ridx];
      if (s_if.cyc & s_if.stb & s_if.we & ~mute)
        for (int b = 0; b < 4; b++)
          if (s_if.sel[b]) mem[ridx][8*b +: 8] <= s_if.dat_ms[8*b +: 8];
    end
  end

  assign s_if.ack    = ~mute & s_if.cyc & s_if.stb & (s_if.we | rd_ack);
  assign s_if.err    = 1'b0;
  assign s_if.rty    = 1'b0;
  assign s_if.dat_sm = rdat;

  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] ref_mem [16];
  bit done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int m, input logic c, input logic s, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic [2:0] ct);
    m_cyc[m] = c; m_stb[m] = s; m_we[m] = w; m_adr[m] = a; m_dat[m] = d; m_cti[m] = ct;
  endtask

  // single classic transfer; starts one cycle in so a preceding drop is seen
  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, output logic [31:0] rd, output bit ok);
    step();
    drv(m, 1'b1, 1'b1, we, adr, wdat, 3'b000);
    ok = 1'b0; rd = '0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (m_ack[m]) begin ok = 1'b1; rd = m_dsm[m]; break; end
      step();
    end
    step();
    drv(m, 1'b0, 1'b0, 1'b0, adr, wdat, 3'b000);
  endtask

  task automatic rnd_master(input int m);
    logic [31:0] rd, wd;
    logic        we;
    bit          ok;
    int          idx;
    while (!done) begin
      repeat ($urandom_range(0, 2)) step();
      idx = $urandom_range(0, 15);
      we  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      xfer(m, we, 32'(idx * 4), wd, rd, ok);
      chk("rnd_timeout", 64'(ok), 64'h1);
      if (ok) begin
        if (we) ref_mem[idx] = wd;
        else    chk("rnd_rdata", 64'(rd), 64'(ref_mem[idx]));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit ok, got;
    logic [2:0] cti_seen;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fwd", 64'({s_if.cyc, s_if.stb, s_if.we}), 64'h0);
    chk("rst_resp", 64'({m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]}), 64'h0);

    // tie after reset goes to m0, one IDLE cycle on handover, next tie to m0
    step(); drv(0, 1, 1, 0, 32'h0, 0, 0); drv(1, 1, 1, 0, 32'h4, 0, 0);
    @(negedge clk); chk("tie_latency", 64'(s_if.cyc), 64'h0);
    step(); @(negedge clk); chk("tie_gnt0", 64'({s_if.cyc, s_if.adr}), 64'({1'b1, 32'h0}));
    step(); @(negedge clk); chk("tie_ack0", 64'({m_ack[0], m_ack[1]}), 64'h2);
    step(); drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("drop_cyc", 64'(s_if.cyc), 64'h0);
    step(); @(negedge clk); chk("handover_idle", 64'(s_if.cyc), 64'h0);
    step(); @(negedge clk); chk("tie_gnt1", 64'({s_if.cyc, s_if.adr}), 64'({1'b1, 32'h4}));
    step(); @(negedge clk); chk("tie_ack1", 64'({m_ack[0], m_ack[1]}), 64'h1);
    step(); drv(1, 0, 0, 0, 0, 0, 0);
    step(); drv(0, 1, 1, 0, 32'h0, 0, 0); drv(1, 1, 1, 0, 32'h4, 0, 0);
    step(); @(negedge clk); chk("tie2_gnt0", 64'({s_if.cyc, s_if.adr}), 64'({1'b1, 32'h0}));
    step(); @(negedge clk); chk("tie2_ack0", 64'({m_ack[0], m_ack[1]}), 64'h2);
    step(); drv(0, 0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0, 0);
    step(); step();

    // single write by m0, then read back
    step(); drv(0, 1, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    @(negedge clk); chk("wr_latency", 64'(s_if.stb), 64'h0);
    step(); @(negedge clk);
    chk("wr_fwd", 64'({s_if.stb, s_if.we, s_if.sel, s_if.adr}), 64'({1'b1, 1'b1, 4'hF, 32'h10}));
    chk("wr_dat", 64'(s_if.dat_ms), 64'hDEADBEEF);
    chk("wr_ack", 64'({m_ack[0], m_ack[1]}), 64'h2);
    step(); drv(0, 0, 0, 0, 0, 0, 0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, ok);
    chk("rd_back", 64'({ok, rd}), 64'({1'b1, 32'hDEADBEEF}));

    // burst read by m1 while m0 waits
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), rd, ok);
      chk("bst_preload", 64'(ok), 64'h1);
    end
    step(); drv(1, 1, 1, 0, 32'h0, 0, 3'b010);
    step(); drv(0, 1, 1, 0, 32'h10, 0, 0);
    @(negedge clk); chk("bst_fwd", 64'({s_if.cyc, s_if.cti}), 64'({1'b1, 3'b010}));
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; rd = '0; cti_seen = '0;
      for (int t = 0; t < 8; t++) begin
        @(negedge clk);
        chk("bst_m0_noack", 64'(m_ack[0]), 64'h0);
        if (m_ack[1]) begin got = 1'b1; rd = m_dsm[1]; cti_seen = s_if.cti; break; end
        step();
      end
      chk("bst_word", 64'({got, rd}), 64'({1'b1, 32'h1000_0000 + 32'(k)}));
      if (k == 3) chk("bst_cti_end", 64'(cti_seen), 64'h7);
      step();
      if (k < 3) drv(1, 1, 1, 0, 32'((k + 1) * 4), 0, (k == 2) ? 3'b111 : 3'b010);
      else       drv(1, 0, 0, 0, 0, 0, 0);
    end
    got = 1'b0; rd = '0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (m_ack[0]) begin got = 1'b1; rd = m_dsm[0]; break; end
      step();
    end
    chk("bst_m0_after", 64'({got, rd}), 64'({1'b1, 32'hDEADBEEF}));
    step(); drv(0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // watchdog: slave silent, m0 errored on 5th cycle after grant, m1 next
    step(); mute = 1'b1; drv(0, 1, 1, 0, 32'h0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) drv(1, 1, 1, 0, 32'h4, 0, 0);
      @(negedge clk);
      chk("wd_err", 64'({m_err[0], s_if.cyc, m_err[1]}), (k == 5) ? 64'h4 : 64'h2);
    end
    step(); @(negedge clk); chk("wd_idle", 64'({s_if.cyc, m_err[0]}), 64'h0);
    step(); mute = 1'b0;
    @(negedge clk); chk("wd_gnt1", 64'({s_if.cyc, s_if.adr}), 64'({1'b1, 32'h4}));
    step(); @(negedge clk); chk("wd_ack1", 64'({m_ack[1], m_err[1], m_ack[0]}), 64'h4);
    step(); drv(0, 0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0, 0);
    step(); step();

    // reset pulse during an m1 burst
    step(); drv(1, 1, 1, 0, 32'h0, 0, 3'b010);
    step();
    step(); rst = 1'b1;
    @(negedge clk); chk("rb_pre_ack", 64'(m_ack[1]), 64'h1);
    step(); rst = 1'b0; drv(0, 1, 1, 0, 32'h8, 0, 0);
    @(negedge clk);
    chk("rb_post", 64'({s_if.cyc, s_if.stb, s_if.we, m_ack[0], m_err[0], m_rty[0],
                        m_ack[1], m_err[1], m_rty[1]}), 64'h0);
    step(); @(negedge clk);
    chk("rb_tie_m0", 64'({s_if.cyc, s_if.adr, m_ack[1]}), 64'({1'b1, 32'h8, 1'b0}));
    step(); drv(0, 0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0, 0);
    step(); step();

    // random two-master traffic against a reference memory (RAM cleared by reset)
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    fork
      begin
        repeat (10000) begin
          @(negedge clk);
          if (m_ack[0] | m_ack[1] | m_err[0] | m_err[1]) begin
            chk("rnd_excl", 64'({m_ack[0] & m_ack[1], m_err[0] | m_err[1]}), 64'h0);
            chk("rnd_ack_gnt", 64'(s_if.cyc), 64'h1);
          end
        end
        done = 1'b1;
      end
      rnd_master(0);
      rnd_master(1);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
